// File: rtl/dmem_access_unit_if.sv
// Data-bus bundle between the memory-stage engine (master) and the data memory (slave).
// Request side is registered by the master; grant/read-return come from the slave.
interface dmem_access_unit_if #(parameter int ADDR_W = 32);
  logic              dbus_req;
  logic              dbus_we;
  logic [ADDR_W-1:0] dbus_addr;
  logic [3:0]        dbus_be;
  logic [31:0]       dbus_wdata;
  logic              dbus_gnt;
  logic              dbus_rvalid;
  logic [31:0]       dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    input  dbus_gnt, dbus_rvalid, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    output dbus_gnt, dbus_rvalid, dbus_rdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store engine: one bus access per op, stalling the pipeline until it
// completes, then returning aligned and extended load data.
module dmem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                EX_MEM_mem_read,
  input  logic                EX_MEM_mem_write,
  input  logic [2:0]          EX_MEM_funct3,
  input  logic [ADDR_W-1:0]   EX_MEM_alu_result,
  input  logic [31:0]         EX_MEM_rs2_data,
  output logic                mem_stall,
  output logic [31:0]         load_data,
  output logic                load_valid,
  output logic                access_err,
  dmem_access_unit_if.master  dbus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  state_t            r_state;
  logic              r_req, r_we, r_load_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata, r_load_data;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;

  logic        w_valid, w_store, w_legal, w_aligned, w_idle, w_go;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_valid = EX_MEM_mem_read | EX_MEM_mem_write;
  assign w_store = EX_MEM_mem_write;

  always_comb begin
    w_legal = 1'b0;
    case (EX_MEM_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~w_store;
      default:                w_legal = 1'b0;
    endcase
    w_aligned = 1'b1;
    case (EX_MEM_funct3[1:0])
      2'b01:   w_aligned = ~EX_MEM_alu_result[0];
      2'b10:   w_aligned = (EX_MEM_alu_result[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  // Gate with rst so the combinational outputs also read 0 while reset is held.
  assign w_idle     = (r_state == S_IDLE) & ~rst;
  assign w_go       = w_idle & w_valid & w_legal & w_aligned;
  assign access_err = w_idle & w_valid & ~(w_legal & w_aligned);
  assign mem_stall  = w_go | (r_state == S_REQ) | (r_state == S_WAIT_R);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = EX_MEM_rs2_data;
    if (w_store) begin
      case (EX_MEM_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << EX_MEM_alu_result[1:0];
          w_wdata = {4{EX_MEM_rs2_data[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << {EX_MEM_alu_result[1], 1'b0};
          w_wdata = {2{EX_MEM_rs2_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign w_byte = dbus.dbus_rdata[{r_off, 3'b000} +: 8];
  assign w_half = dbus.dbus_rdata[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_ext = r_funct3[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ext = r_funct3[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ext = dbus.dbus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_funct3     <= '0;
      r_off        <= '0;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
    end else begin
      r_load_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_go) begin
          r_state  <= S_REQ;
          r_req    <= 1'b1;
          r_we     <= w_store;
          r_addr   <= {EX_MEM_alu_result[ADDR_W-1:2], 2'b00};
          r_be     <= w_be;
          r_wdata  <= w_store ? w_wdata : 32'h0;
          r_funct3 <= EX_MEM_funct3;
          r_off    <= EX_MEM_alu_result[1:0];
        end
        S_REQ: if (dbus.dbus_gnt) begin
          r_state <= r_we ? S_DONE : S_WAIT_R;
          r_req   <= 1'b0;
          r_we    <= 1'b0;
          r_addr  <= '0;
          r_be    <= '0;
          r_wdata <= '0;
        end
        S_WAIT_R: if (dbus.dbus_rvalid) begin
          r_load_data  <= w_ext;
          r_load_valid <= 1'b1;
          r_state      <= S_DONE;
        end
        // The EX/MEM register still holds this op during DONE, so it is not resampled.
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dbus.dbus_req   = r_req;
  assign dbus.dbus_we    = r_we;
  assign dbus.dbus_addr  = r_addr;
  assign dbus.dbus_be    = r_be;
  assign dbus.dbus_wdata = r_wdata;
  assign load_data       = r_load_data;
  assign load_valid      = r_load_valid;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: bus requests and load results are queued when an
// op is presented and compared when the DUT issues/returns them.
module tb_dmem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_result, rs2_data;
  logic        mem_stall, load_valid, access_err;
  logic [31:0] load_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  bus_t        bq[$];
  logic [31:0] lq[$];

  dmem_access_unit_if #(.ADDR_W(32)) dbus ();

  dmem_access_unit #(.ADDR_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .EX_MEM_mem_read   (mem_read),
    .EX_MEM_mem_write  (mem_write),
    .EX_MEM_funct3     (funct3),
    .EX_MEM_alu_result (alu_result),
    .EX_MEM_rs2_data   (rs2_data),
    .mem_stall         (mem_stall),
    .load_data         (load_data),
    .load_valid        (load_valid),
    .access_err        (access_err),
    .dbus              (dbus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req"},   dbus.dbus_req,   0);
    chk({tag, ".we"},    dbus.dbus_we,    0);
    chk({tag, ".addr"},  dbus.dbus_addr,  0);
    chk({tag, ".be"},    dbus.dbus_be,    0);
    chk({tag, ".wdata"}, dbus.dbus_wdata, 0);
    chk({tag, ".ldata"}, load_data,       0);
    chk({tag, ".lvld"},  load_valid,      0);
    chk({tag, ".err"},   access_err,      0);
    chk({tag, ".stall"}, mem_stall,       0);
  endtask

  task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
    mem_read = rd; mem_write = wr; funct3 = f3; alu_result = a; rs2_data = d;
  endtask

  // One complete legal op: gdly idle-grant cycles in REQ, optional rvalid noise while in REQ.
  task automatic op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] d, input int gdly,
                    input logic [31:0] rdat, input logic [3:0] ebe, input logic [31:0] ewd,
                    input logic [31:0] eld, input bit rv_noise);
    bus_t b;
    bit   is_load;
    int   nst;
    is_load = rd & ~wr;
    b.we = wr; b.addr = {a[31:2], 2'b00}; b.be = ebe; b.wdata = ewd;
    bq.push_back(b);
    if (is_load) lq.push_back(eld);
    nst = 0;

    @(posedge clk); #1;
    drive_op(rd, wr, f3, a, d);
    #1;
    chk({tag, ".c0_err"}, access_err, 0);
    chk({tag, ".c0_req"}, dbus.dbus_req, 0);
    if (mem_stall) nst++;

    for (int c = 0; c <= gdly; c++) begin
      @(posedge clk); #1;
      dbus.dbus_gnt    = (c == gdly);
      dbus.dbus_rvalid = rv_noise && (c < gdly);
      dbus.dbus_rdata  = 32'h5A5A_5A5A;
      #1;
      chk({tag, ".req"}, dbus.dbus_req, 1);
      if (bq.size() > 0) begin
        chk({tag, ".we"},   dbus.dbus_we,   bq[0].we);
        chk({tag, ".addr"}, dbus.dbus_addr, bq[0].addr);
        chk({tag, ".be"},   dbus.dbus_be,   bq[0].be);
        if (bq[0].we) chk({tag, ".wdata"}, dbus.dbus_wdata, bq[0].wdata);
      end
      if (mem_stall) nst++;
    end
    if (bq.size() > 0) void'(bq.pop_front());

    if (is_load) begin
      @(posedge clk); #1;
      dbus.dbus_gnt = 1'b0; dbus.dbus_rvalid = 1'b1; dbus.dbus_rdata = rdat;
      #1;
      chk({tag, ".wr_req"}, dbus.dbus_req, 0);
      if (mem_stall) nst++;
    end

    // DONE
    @(posedge clk); #1;
    dbus.dbus_gnt = 1'b0; dbus.dbus_rvalid = 1'b0; dbus.dbus_rdata = 32'h0;
    #1;
    if (mem_stall) nst++;
    chk({tag, ".done_req"}, dbus.dbus_req, 0);
    chk({tag, ".lvld"}, load_valid, is_load);
    if (load_valid && lq.size() > 0) chk({tag, ".ldata"}, load_data, lq.pop_front());
    chk({tag, ".stall_cycles"}, nst, gdly + 2 + (is_load ? 1 : 0));

    // Mandatory IDLE gap
    @(posedge clk); #1;
    drive_op(0, 0, 3'b000, 32'h0, 32'h0);
    #1;
    chk({tag, ".gap_lvld"},  load_valid, 0);
    chk({tag, ".gap_stall"}, mem_stall,  0);
  endtask

  task automatic err_op(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a);
    @(posedge clk); #1;
    drive_op(rd, wr, f3, a, 32'hFFFF_FFFF);
    #1;
    chk({tag, ".err"},   access_err,    1);
    chk({tag, ".stall"}, mem_stall,     0);
    chk({tag, ".req"},   dbus.dbus_req, 0);
    @(posedge clk); #1;
    drive_op(0, 0, 3'b000, 32'h0, 32'h0);
    #1;
    chk({tag, ".err_end"}, access_err,    0);
    chk({tag, ".req_end"}, dbus.dbus_req, 0);
  endtask

  initial begin
    rst = 1'b1;
    drive_op(0, 0, 3'b000, 32'h0, 32'h0);
    dbus.dbus_gnt = 1'b0; dbus.dbus_rvalid = 1'b0; dbus.dbus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst_held");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("rst_rel");

    //  tag    rd wr f3      addr         rs2          gdly rdata        be       wdata        load         noise
    op("SW",   0, 1, 3'b010, 32'h100,     32'hDEADBEEF, 2, 32'h0,        4'b1111, 32'hDEADBEEF, 32'h0,       0);
    op("SB",   0, 1, 3'b000, 32'h103,     32'h000000A5, 0, 32'h0,        4'b1000, 32'hA5A5A5A5, 32'h0,       0);
    op("SH",   0, 1, 3'b001, 32'h102,     32'h00001234, 0, 32'h0,        4'b1100, 32'h12341234, 32'h0,       0);
    op("SB0",  0, 1, 3'b000, 32'h100,     32'h123456C3, 1, 32'h0,        4'b0001, 32'hC3C3C3C3, 32'h0,       0);
    op("LB",   1, 0, 3'b000, 32'h101,     32'h0,        0, 32'h000080FF, 4'b1111, 32'h0,        32'hFFFFFF80, 0);
    op("LBU",  1, 0, 3'b100, 32'h101,     32'h0,        1, 32'h000080FF, 4'b1111, 32'h0,        32'h00000080, 1);
    op("LHU",  1, 0, 3'b101, 32'h102,     32'h0,        0, 32'h80010000, 4'b1111, 32'h0,        32'h00008001, 0);
    op("LH",   1, 0, 3'b001, 32'h100,     32'h0,        0, 32'h00009ABC, 4'b1111, 32'h0,        32'hFFFF9ABC, 0);
    op("LW",   1, 0, 3'b010, 32'h104,     32'h0,        2, 32'h11223344, 4'b1111, 32'h0,        32'h11223344, 1);

    err_op("LW_mis",   1, 0, 3'b010, 32'h102);
    err_op("L011",     1, 0, 3'b011, 32'h100);
    err_op("SH_mis",   0, 1, 3'b001, 32'h101);
    err_op("S_f3_100", 0, 1, 3'b100, 32'h100);

    // Reset while waiting for read data; a late rvalid must be ignored.
    @(posedge clk); #1;
    drive_op(1, 0, 3'b000, 32'h100, 32'h0);
    #1;
    chk("rstmid.c0_stall", mem_stall, 1);
    @(posedge clk); #1;
    dbus.dbus_gnt = 1'b1;
    #1;
    chk("rstmid.req", dbus.dbus_req, 1);
    @(posedge clk); #1;
    dbus.dbus_gnt = 1'b0; rst = 1'b1;
    drive_op(0, 0, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; dbus.dbus_rvalid = 1'b1; dbus.dbus_rdata = 32'h0000_0055;
    #1;
    chk_all_zero("rstmid.a");
    @(posedge clk); #1;
    dbus.dbus_rvalid = 1'b0; dbus.dbus_rdata = 32'h0;
    #1;
    chk_all_zero("rstmid.b");

    op("BOTH", 1, 1, 3'b010, 32'h200, 32'hCAFEF00D, 0, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h0, 0);

    chk("bus_queue_empty",  bq.size(), 0);
    chk("load_queue_empty", lq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory-stage load/store engine for the RISC-V pipeline. Consumes the `mem_read`/`mem_write` decisions made in ID and carried to the EX/MEM register. Drives a request/grant/read-valid data bus, generating byte enables and store-data replication. Stalls the pipeline until the access completes and returns aligned, sign- or zero-extended load data to the MEM/WB path.

## Interface
- `ADDR_W`, default 32: byte-address width on the bus.
- `clk`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `EX_MEM_mem_read`  in  1  load request from the EX/MEM register.
- `EX_MEM_mem_write`  in  1  store request from the EX/MEM register.
- `EX_MEM_funct3`  in  3  instruction bits [14:12]; access size and signedness.
- `EX_MEM_alu_result`  in  ADDR_W  effective byte address.
- `EX_MEM_rs2_data`  in  32  store data, unshifted.
- `mem_stall`  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- `load_data`  out  32  extended load result, valid with `load_valid`.
- `load_valid`  out  1  one-cycle pulse, load complete.
- `access_err`  out  1  one-cycle pulse, misaligned or illegal funct3; no bus access made.
- `dbus_req`  out  1  bus request.
- `dbus_we`  out  1  1 = write.
- `dbus_addr`  out  ADDR_W  word-aligned address (`[1:0]` = 0).
- `dbus_be`  out  4  byte enables.
- `dbus_wdata`  out  32  replicated store data.
- `dbus_gnt`  in  1  request accepted this cycle.
- `dbus_rvalid`  in  1  read data valid.
- `dbus_rdata`  in  32  read data.

## Operation
- An op is valid when `mem_read | mem_write`.
  - If both are high, the op is a store.
- Legal loads by funct3:
  - 000 LB, 001 LH, 010 LW: sign-extended.
  - 100 LBU, 101 LHU: zero-extended.
- Legal stores by funct3: 000 SB, 001 SH, 010 SW.
- Alignment:
  - Halfword requires `addr[0]=0`.
  - Word requires `addr[1:0]=0`.
  - Byte is always aligned.
- An illegal funct3 or a misaligned address:
  - Pulses `access_err` for one cycle in IDLE.
  - Makes no request, asserts no stall, and stays in IDLE.
- FSM states: IDLE, REQ, WAIT_R, DONE.
  - IDLE → REQ on a valid legal op. Latch address, be, wdata, we, funct3 and `addr[1:0]`.
  - REQ: `dbus_req=1`. On `gnt`: store → DONE, load → WAIT_R. Without `gnt`, stay in REQ.
  - WAIT_R: on `rvalid`, capture the extended data into `load_data` and go to DONE.
  - DONE: one cycle, `mem_stall=0`. Pulse `load_valid` for loads. Go to IDLE. Inputs are not sampled in DONE, because the same op is still presented.
- `mem_stall` = (IDLE & valid legal op) | REQ | WAIT_R. This is combinational from the inputs in IDLE.
- `dbus_be`:
  - SB: `4'b0001 << addr[1:0]`.
  - SH: `4'b0011 << {addr[1],1'b0}`.
  - SW and all loads: `4'b1111`.
- `dbus_wdata`: SB `{4{rs2[7:0]}}`, SH `{2{rs2[15:0]}}`, SW `rs2`.
- Load extraction:
  - Byte lane = `rdata >> (8*addr[1:0])`.
  - Halfword lane = `rdata >> (16*addr[1])`.
  - Extend the lane per funct3[2].
- `dbus_*` outputs are registered and held stable from REQ entry until `gnt`. They are 0 outside REQ.

## Timing
- Reset: state IDLE. These outputs are 0:
  - `dbus_req`, `dbus_we`, `dbus_addr`, `dbus_be`, `dbus_wdata`
  - `load_data`, `load_valid`, `access_err`, `mem_stall`
- Reset mid-transaction abandons the access immediately. A late `rvalid` is ignored.
- Store, zero-wait bus: op at cycle 0, REQ with `gnt` at cycle 1, DONE at cycle 2. Stall is high in cycles 0–1.
- Load, zero-wait bus: op at cycle 0, REQ with `gnt` at cycle 1, `rvalid` at cycle 2, DONE with `load_valid` at cycle 3.
- `rvalid` is only honoured in WAIT_R; `rvalid` in REQ is ignored.
- Back-to-back ops: after DONE, one IDLE cycle is required before the next op is accepted.
- `access_err` is asserted combinationally in the presenting cycle and lasts exactly one cycle.

## Test plan
- SW: addr 0x100, rs2 0xDEADBEEF, `gnt` held 2 cycles late → `dbus_addr`=0x100, `be`=1111, `wdata`=0xDEADBEEF, all stable across the wait; stall for 4 cycles; DONE follows.
- SB: addr 0x103, rs2 0x000000A5 → `be`=1000, `wdata`=0xA5A5A5A5. SH at 0x102 with rs2 0x1234 → `be`=1100, `wdata`=0x12341234.
- LB at 0x101, rdata 0x0000_80FF → `load_data`=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102, rdata 0x8001_0000 → 0x00008001. `load_valid` is a single pulse.
- LW at 0x102 → `access_err` pulse, no `dbus_req`, `mem_stall`=0. Funct3 011 load at 0x100 → same result.
- Load with `gnt` at cycle 1, assert `rst` at cycle 2 before `rvalid`; `rvalid` at cycle 3 → all outputs 0, state IDLE, no `load_valid`.
- `mem_read` and `mem_write` both high, funct3 010, addr 0x200 → store on bus with `dbus_we`=1 and no `load_valid`.
